// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
// Shared definitions for the ARC4 blocks (key schedule, PRGA, top level).
//   arc4_state_e : key-schedule state encoding
//   BYTE_W       : datapath width of the S-box and key bytes
//   SBOX_DEPTH   : number of S-box entries
//   byte_inc     : wrapping 8-bit increment used for the S-box index
// -----------------------------------------------------------------------------
package arc4_pkg;

  localparam int BYTE_W     = 8;
  localparam int SBOX_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RD_I  = 3'd2,
    CAP_I = 3'd3,
    RD_J  = 3'd4,
    CAP_J = 3'd5,
    WR_I  = 3'd6,
    WR_J  = 3'd7
  } arc4_state_e;

  // Wrapping increment; the carry out of bit 7 is dropped on purpose.
  function automatic logic [BYTE_W-1:0] byte_inc(input logic [BYTE_W-1:0] v);
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/ksa_gen.sv
// -----------------------------------------------------------------------------
// ksa_gen
// ARC4 key-scheduling engine driving an external 256 x 8 S-memory.
// Optionally fills S[i]=i first, then runs 256 swap iterations of 6 cycles.
//
// Parameters
//   KEY_BYTES : key length in bytes (1..32)
//   INIT_EN   : 1 = identity-fill pass before scheduling, 0 = schedule only
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   en     : start request, sampled only while rdy=1
//   rdy    : idle / ready to accept en
//   key    : key, byte 0 in the most significant byte
//   addr   : S-memory address
//   rddata : S-memory read data, valid the cycle after a read address
//   wrdata : S-memory write data
//   wren   : S-memory write enable
// -----------------------------------------------------------------------------
module ksa_gen
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int INIT_EN   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     rdy,
  input  logic [8*KEY_BYTES-1:0]   key,
  output logic [BYTE_W-1:0]        addr,
  input  logic [BYTE_W-1:0]        rddata,
  output logic [BYTE_W-1:0]        wrdata,
  output logic                     wren
);

  // Key-byte counter width; a one-byte key still gets a 1-bit counter.
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_IDX = 8'(SBOX_DEPTH - 1);
  localparam logic [KW-1:0]     LAST_K   = KW'(KEY_BYTES - 1);

  generate
    if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
      $error("ksa_gen: KEY_BYTES must be in 1..32");
    end
  endgenerate

  arc4_state_e              state_r;
  logic [8*KEY_BYTES-1:0]   key_r;
  logic [BYTE_W-1:0]        i_r;
  logic [BYTE_W-1:0]        j_r;
  logic [KW-1:0]            k_r;
  logic [BYTE_W-1:0]        si_r;
  logic [BYTE_W-1:0]        sj_r;

  // Key-schedule sequencer: state, indices and captured S values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      key_r   <= {(8*KEY_BYTES){1'b0}};
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      k_r     <= {KW{1'b0}};
      si_r    <= 8'd0;
      sj_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) begin
            // Key is latched here so later changes on the port are ignored.
            key_r <= key;
            i_r   <= 8'd0;
            j_r   <= 8'd0;
            k_r   <= {KW{1'b0}};
            if (INIT_EN != 0) begin
              state_r <= INIT;
            end else begin
              state_r <= RD_I;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        INIT: begin
          // i wraps 255 -> 0, which is exactly the start index for scheduling.
          i_r <= byte_inc(i_r);
          if (i_r == LAST_IDX) begin
            state_r <= RD_I;
          end else begin
            state_r <= INIT;
          end
        end
        RD_I: begin
          state_r <= CAP_I;
        end
        CAP_I: begin
          si_r    <= rddata;
          j_r     <= j_r + rddata + key_r[8*(KEY_BYTES-1-int'(k_r)) +: 8];
          state_r <= RD_J;
        end
        RD_J: begin
          state_r <= CAP_J;
        end
        CAP_J: begin
          sj_r    <= rddata;
          state_r <= WR_I;
        end
        WR_I: begin
          state_r <= WR_J;
        end
        WR_J: begin
          if (i_r == LAST_IDX) begin
            state_r <= IDLE;
          end else begin
            i_r <= byte_inc(i_r);
            if (k_r == LAST_K) begin
              k_r <= {KW{1'b0}};
            end else begin
              k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
            end
            state_r <= RD_I;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Moore output decode: memory port and ready flag from state and registers.
  always_comb begin
    rdy    = 1'b0;
    wren   = 1'b0;
    addr   = 8'd0;
    wrdata = 8'd0;
    case (state_r)
      IDLE: begin
        rdy = 1'b1;
      end
      INIT: begin
        wren   = 1'b1;
        addr   = i_r;
        wrdata = i_r;
      end
      RD_I, CAP_I: begin
        addr = i_r;
      end
      RD_J, CAP_J: begin
        addr = j_r;
      end
      WR_I: begin
        wren   = 1'b1;
        addr   = i_r;
        wrdata = sj_r;
      end
      WR_J: begin
        wren   = 1'b1;
        addr   = j_r;
        wrdata = si_r;
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

endmodule
